// File: rtl/interrupt_arbiter.sv
// Synchronises and edge-detects interrupt lines, holds them pending behind a mask,
// and grants one at a time (lowest index first) with a vector address; all outputs registered.
module interrupt_arbiter #(
    parameter int                DATA_WIDTH = 8,
    parameter int                ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] MASK_ADDR  = 16'hFF00,
    parameter logic [ADDR_WIDTH-1:0] PEND_ADDR  = 16'hFF01,
    parameter logic [ADDR_WIDTH-1:0] ISR_ADDR   = 16'hFF02,
    parameter logic [ADDR_WIDTH-1:0] EOI_ADDR   = 16'hFF03,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 16'h0010,
    parameter int                VEC_STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] irq_in,
    input  logic                  we,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  irq_req,
    output logic [ADDR_WIDTH-1:0] irq_vec,
    input  logic                  irq_ack,
    output logic [DATA_WIDTH-1:0] in_service
);
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   sync1_q, sync2_q, prev_q;
    logic [DATA_WIDTH-1:0]   pend_q, pend_d, mask_q, isr_q, rdata_q, rd_val;
    logic [IW-1:0]           idx_q, win_idx;
    logic                    win_vld;
    logic                    irq_req_q;
    logic [ADDR_WIDTH-1:0]   irq_vec_q;
    logic [DATA_WIDTH-1:0]   eligible, edge_det, idx_onehot, clr_bits;
    logic                    wr_mask, wr_pend, wr_eoi, win_ok, ack_take;

    assign wr_mask    = we && (addr == MASK_ADDR);
    assign wr_pend    = we && (addr == PEND_ADDR);
    assign wr_eoi     = we && (addr == EOI_ADDR);
    assign edge_det   = sync2_q & ~prev_q;
    assign eligible   = pend_q & mask_q;
    assign idx_onehot = DATA_WIDTH'(1) << idx_q;
    assign win_ok     = pend_q[idx_q] & mask_q[idx_q];
    assign ack_take   = (state_q == REQ) && win_ok && irq_ack;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end

    // A fresh edge is OR'ed in last so it beats a same-cycle software clear.
    always_comb begin
        clr_bits = '0;
        if (wr_pend)  clr_bits = clr_bits | wdata;
        if (ack_take) clr_bits = clr_bits | idx_onehot;
        pend_d = (pend_q & ~clr_bits) | edge_det;
    end

    always_comb begin
        rd_val = '0;
        if (addr == MASK_ADDR)      rd_val = mask_q;
        else if (addr == PEND_ADDR) rd_val = pend_q;
        else if (addr == ISR_ADDR)  rd_val = isr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
            if (wr_mask) mask_q <= wdata;
            if (rd)      rdata_q <= rd_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            irq_req_q <= 1'b0;
            irq_vec_q <= '0;
            isr_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        idx_q     <= win_idx;
                        irq_req_q <= 1'b1;
                        irq_vec_q <= VEC_BASE + ADDR_WIDTH'(win_idx) * ADDR_WIDTH'(VEC_STRIDE);
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (!win_ok) begin
                        irq_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (irq_ack) begin
                        irq_req_q <= 1'b0;
                        isr_q     <= idx_onehot;
                        state_q   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        isr_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    irq_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign irq_req    = irq_req_q;
    assign irq_vec    = irq_vec_q;
    assign in_service = isr_q;
endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter; expectations queued at stimulus time, compared at output.
module tb_interrupt_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_in = '0;
    logic        we = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic        irq_ack = 1'b0;
    logic [7:0]  in_service;

    localparam logic [15:0] A_MASK = 16'hFF00;
    localparam logic [15:0] A_PEND = 16'hFF01;
    localparam logic [15:0] A_ISR  = 16'hFF02;
    localparam logic [15:0] A_EOI  = 16'hFF03;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    interrupt_arbiter dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .rd(rd), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irq_req(irq_req), .irq_vec(irq_vec),
        .irq_ack(irq_ack), .in_service(in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push_exp(tag, e);
        pop_cmp(obs);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] e);
        push_exp(tag, {24'h0, e});
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0; addr = '0;
        pop_cmp({24'h0, rdata});
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (irq_req !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'h0, irq_req}, 32'h1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_rdata", {24'h0, rdata}, 32'h0);
        check("rst_req", {31'h0, irq_req}, 32'h0);
        check("rst_vec", {16'h0, irq_vec}, 32'h0);
        check("rst_isr", {24'h0, in_service}, 32'h0);
        bus_read("rst_mask_rd", A_MASK, 8'h00);

        // Single line, exact latency
        bus_write(A_MASK, 8'h04);
        irq_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_req_early", {31'h0, irq_req}, 32'h0);
        @(negedge clk);
        check("lat_req", {31'h0, irq_req}, 32'h1);
        check("lat_vec", {16'h0, irq_vec}, 32'h0018);
        ack_pulse();
        check("ack_isr", {24'h0, in_service}, 32'h04);
        check("ack_req", {31'h0, irq_req}, 32'h0);
        bus_read("ack_pend_rd", A_PEND, 8'h00);
        bus_read("ack_isr_rd", A_ISR, 8'h04);
        bus_read("unmapped_rd", 16'h1234, 8'h00);
        bus_write(A_EOI, 8'h00);
        check("eoi_isr", {24'h0, in_service}, 32'h00);
        irq_in = '0;
        repeat (3) @(negedge clk);

        // Priority and no nesting
        bus_write(A_MASK, 8'hFF);
        irq_in[5] = 1'b1; irq_in[1] = 1'b1;
        wait_req("pri_req", 10);
        check("pri_vec", {16'h0, irq_vec}, 32'h0014);
        ack_pulse();
        check("pri_isr", {24'h0, in_service}, 32'h02);
        irq_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("nonest_req", {31'h0, irq_req}, 32'h0);
        bus_read("nonest_pend_rd", A_PEND, 8'h21);
        bus_write(A_EOI, 8'h00);
        @(negedge clk);
        check("eoi1_req", {31'h0, irq_req}, 32'h1);
        check("eoi1_vec", {16'h0, irq_vec}, 32'h0010);
        ack_pulse();
        bus_write(A_EOI, 8'h00);
        @(negedge clk);
        check("eoi2_req", {31'h0, irq_req}, 32'h1);
        check("eoi2_vec", {16'h0, irq_vec}, 32'h0024);
        ack_pulse();
        bus_write(A_EOI, 8'h00);
        irq_in = '0;
        repeat (3) @(negedge clk);
        check("drain_req", {31'h0, irq_req}, 32'h0);

        // Withdraw by masking during REQ
        irq_in[3] = 1'b1;
        wait_req("wd_req", 10);
        check("wd_vec", {16'h0, irq_vec}, 32'h001C);
        bus_write(A_MASK, 8'h00);
        @(negedge clk);
        check("wd_drop", {31'h0, irq_req}, 32'h0);
        bus_read("wd_pend_rd", A_PEND, 8'h08);
        bus_write(A_PEND, 8'h08);
        bus_read("w1c_pend_rd", A_PEND, 8'h00);
        irq_in = '0;
        repeat (3) @(negedge clk);

        // Edge set and software clear in the same cycle: set wins
        irq_in[1] = 1'b1;
        repeat (2) @(negedge clk);
        bus_write(A_PEND, 8'h02);
        bus_read("coll_pend_rd", A_PEND, 8'h02);
        bus_write(A_PEND, 8'h02);
        bus_read("coll_clr_rd", A_PEND, 8'h00);
        irq_in = '0;
        repeat (3) @(negedge clk);

        // Reset while in service
        bus_write(A_MASK, 8'h01);
        irq_in[0] = 1'b1;
        wait_req("rs_req", 10);
        ack_pulse();
        check("rs_isr", {24'h0, in_service}, 32'h01);
        bus_read("rs_mask_rd", A_MASK, 8'h01);
        rst = 1'b1;
        #1;
        check("rs_rdata", {24'h0, rdata}, 32'h0);
        check("rs_req0", {31'h0, irq_req}, 32'h0);
        check("rs_vec", {16'h0, irq_vec}, 32'h0);
        check("rs_isr0", {24'h0, in_service}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rs_noreq", {31'h0, irq_req}, 32'h0);
        bus_read("rs_isr_rd", A_ISR, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
